// File: rtl/mem_snoop_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_snoop_arbiter
// Purpose : Shares a single-port data memory between the CPU port and a snoop
//           sweep that copies mem[SNOOP_BASE +: SNOOP_CNT] into shadow words.
//           Optional macro SNOOP_WRITE_TRACK_EN mirrors CPU window writes
//           straight into the shadow words.
// Revision: 1.0 - initial release
// ============================================================================
module mem_snoop_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int SNOOP_BASE = 20,
    parameter int SNOOP_CNT  = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [AW-1:0]           cpu_addr,
    input  logic [DW-1:0]           cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DW-1:0]           cpu_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    input  logic                    snoop_start,
    output logic                    snoop_busy,
    output logic                    snoop_done,
    output logic [SNOOP_CNT*DW-1:0] shadow
);

    localparam int IW = (SNOOP_CNT > 1) ? $clog2(SNOOP_CNT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [IW-1:0] LAST_IDX   = IW'(SNOOP_CNT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [1:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic                    cap_pend_q;
    logic [IW-1:0]           cap_idx_q;
    logic                    rvalid_q;
    logic [SNOOP_CNT*DW-1:0] shadow_q;

    logic                    w_sweep;
    logic                    w_cpu_win;
    logic                    w_snoop_win;
    logic [AW-1:0]           w_snoop_addr;

    // CPU has priority unless it has already starved a pending snoop slot.
    assign w_sweep      = (state_q == S_SWEEP);
    assign w_cpu_win    = !rst && cpu_req && (!w_sweep || (starve_q < STARVE_LIM));
    assign w_snoop_win  = !rst && w_sweep && !w_cpu_win;
    assign w_snoop_addr = AW'(SNOOP_BASE) + AW'(idx_q);

    assign cpu_gnt    = w_cpu_win;
    assign mem_en     = w_cpu_win || w_snoop_win;
    assign mem_we     = w_cpu_win && cpu_we;
    assign mem_addr   = w_cpu_win ? cpu_addr : (w_snoop_win ? w_snoop_addr : '0);
    assign mem_wdata  = (w_cpu_win && cpu_we) ? cpu_wdata : '0;

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rvalid_q ? mem_rdata : '0;
    assign snoop_busy = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign snoop_done = !rst && (state_q == S_DRAIN);
    assign shadow     = shadow_q;

`ifdef SNOOP_WRITE_TRACK_EN
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] WIN_LO = AW1'(SNOOP_BASE);
    localparam logic [AW:0] WIN_HI = AW1'(SNOOP_BASE + SNOOP_CNT);

    logic          w_track;
    logic [IW-1:0] w_track_idx;

    assign w_track     = w_cpu_win && cpu_we &&
                         ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
    assign w_track_idx = IW'(cpu_addr - AW'(SNOOP_BASE));
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        starve_d = starve_q;
        case (state_q)
            S_IDLE: begin
                if (snoop_start) begin
                    state_d  = S_SWEEP;
                    idx_d    = '0;
                    starve_d = '0;
                end
            end
            S_SWEEP: begin
                if (w_snoop_win) begin
                    starve_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (w_cpu_win) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            starve_q   <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
            rvalid_q   <= 1'b0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            starve_q   <= starve_d;
            cap_pend_q <= w_snoop_win;
            cap_idx_q  <= idx_q;
            rvalid_q   <= w_cpu_win && !cpu_we;
            // Later assignment wins: a tracked CPU write overrides a same-edge capture.
            for (int i = 0; i < SNOOP_CNT; i++) begin
                if (cap_pend_q && (cap_idx_q == IW'(i)))
                    shadow_q[i*DW +: DW] <= mem_rdata;
`ifdef SNOOP_WRITE_TRACK_EN
                if (w_track && (w_track_idx == IW'(i)))
                    shadow_q[i*DW +: DW] <= cpu_wdata;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_snoop_arbiter.md
# mem_snoop_arbiter

Shares the core's single-port data memory between the CPU load/store port and a snoop sequencer. The sequencer sweeps a fixed address window (default 20..30) into shadow registers that drive the result outputs of `top`. CPU accesses have priority. A starvation guard guarantees the sweep progresses under continuous CPU traffic.

## Interface
Parameters:
- `AW`, 8, memory address width
- `DW`, 8, memory data width
- `SNOOP_BASE`, 20, first snooped address
- `SNOOP_CNT`, 11, number of snooped words (1..2^AW−SNOOP_BASE)
- `STARVE_MAX`, 4, consecutive CPU grants tolerated while a snoop slot is pending

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  CPU write (1) / read (0)
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  access issued to memory this cycle (combinational)
- `cpu_rvalid`  out  1  read data valid (cycle after granted read)
- `cpu_rdata`  out  DW  `mem_rdata` when `cpu_rvalid`, else 0
- `mem_en`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  synchronous read data, 1-cycle latency
- `snoop_start`  in  1  start a sweep (pulse)
- `snoop_busy`  out  1  sweep in progress
- `snoop_done`  out  1  one-cycle pulse at sweep completion
- `shadow`  out  SNOOP_CNT*DW  shadow words; word i at bits [i*DW +: DW] = mem[SNOOP_BASE+i]

## Operation
- FSM states: IDLE, SWEEP, DRAIN.
- IDLE → SWEEP when `snoop_start` is high. Clear `idx` and `starve_cnt`. `snoop_start` is ignored in SWEEP and DRAIN.
- In SWEEP a snoop slot is pending every cycle.
- Arbitration, per cycle:
  - If `cpu_req` and (state≠SWEEP or `starve_cnt`<STARVE_MAX): CPU wins, `cpu_gnt`=1.
  - Otherwise, in SWEEP, the snoop wins: read at SNOOP_BASE+`idx`, `cpu_gnt`=0. The CPU holds its request until granted.
- `starve_cnt` increments on each CPU grant in SWEEP and clears on each snoop slot.
- Snoop slot: `idx` increments. If `idx`=SNOOP_CNT−1 when the slot issues, go to DRAIN.
- Snoop read data is captured the following cycle into `shadow[idx_issued]`. Track this with a registered pending flag and index.
- DRAIN lasts exactly one cycle, during which the last capture occurs. Then go to IDLE and raise `snoop_done` for that cycle.
- `snoop_busy` = state∈{SWEEP, DRAIN}.
- Memory port is idle (`mem_en`=0) when neither requester is granted. `mem_*` outputs are combinational from the arbitration.
- No address checks: CPU accesses outside the window pass through unchanged.

## Timing
- Reset: state IDLE; `idx`, `starve_cnt`, pending flags, `shadow` all 0. `cpu_gnt`, `cpu_rvalid`, `snoop_busy`, `snoop_done`, `mem_en`, `mem_we` are 0. `mem_addr`, `mem_wdata`, `cpu_rdata` are 0.
- While `rst` is high, nothing is granted regardless of `cpu_req`.
- Reset mid-sweep aborts the sweep with no `snoop_done` pulse. Any capture due the next cycle is discarded.
- CPU read latency: grant at cycle t → `cpu_rvalid`=1 at t+1. Writes complete in the grant cycle.
- Uncontended sweep: `snoop_start` at t → slots t+1..t+SNOOP_CNT → `snoop_done` at t+SNOOP_CNT+1.
- Worst-case sweep under continuous `cpu_req`: SNOOP_CNT×(STARVE_MAX+1)+1 cycles after start.
- Sweep of a word and CPU write to the same address in adjacent cycles: see `SNOOP_WRITE_TRACK_EN`.

## Configuration
- `SNOOP_WRITE_TRACK_EN` defined:
  - A granted CPU write with SNOOP_BASE ≤ `cpu_addr` < SNOOP_BASE+SNOOP_CNT also writes `cpu_wdata` into the matching shadow word at the same clock edge. This applies in any state.
  - If a sweep capture targets the same word in the same cycle, the write-track value wins.
- Not defined: `shadow` changes only through sweep captures. CPU writes become visible at the next sweep.

## Test plan
- Reset, then preload mem[20..30]=1..11 and pulse `snoop_start` with no CPU traffic → `snoop_busy` for 12 cycles, `snoop_done` 12 cycles after start, `shadow` words = 1..11.
- Hold `cpu_req`=1 (reads of address 5) continuously through a sweep → pattern of 4 CPU grants then 1 snoop slot, repeated. `snoop_done` 56 cycles after start. Every CPU read returns mem[5] with `cpu_rvalid` one cycle after its grant.
- Pulse `snoop_start` again at cycle 3 of a sweep → ignored. One `snoop_done` only, `idx` sequence unaffected.
- Assert `rst` on the 6th snoop slot → next cycle idle, no `snoop_done`, `shadow`=0, CPU granted immediately after `rst` drops.
- With `SNOOP_WRITE_TRACK_EN`, in IDLE, CPU writes 0xA5 to address 25 → `shadow` word 5 = 0xA5 at the next edge. Without the macro → word 5 is unchanged until the next sweep, then reads 0xA5.
- With `SNOOP_WRITE_TRACK_EN`, snoop reads address 22 at t and CPU writes 0x3C to 22 at t+1 → `shadow` word 2 = 0x3C after t+1.
